// File: rtl/mips_muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: 32-step shift-add multiplier and
// restoring divider with sign fix-up, plus MTHI/MTLO writes while idle.
module mips_muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_value,
  input  logic [31:0] rt_value,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] mcand_q, mcand_d;  // multiplicand, or divisor
  logic [31:0] shreg_q, shreg_d;  // multiplier, or dividend shifting into quotient
  logic [63:0] acc_q, acc_d;
  logic [32:0] rem_q, rem_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic        rs_neg, rt_neg, div_zero;
  logic [31:0] rs_mag, rt_mag;
  logic [32:0] mul_sum;
  logic [32:0] rem_shift;
  logic [33:0] rem_trial;
  logic [63:0] product;
  logic [31:0] quot_fix, rem_fix;

  always_comb begin
    rs_neg    = ~op[0] & rs_value[31];
    rt_neg    = ~op[0] & rt_value[31];
    rs_mag    = rs_neg ? (32'd0 - rs_value) : rs_value;
    rt_mag    = rt_neg ? (32'd0 - rt_value) : rt_value;
    div_zero  = (rt_value == '0);

    mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, (shreg_q[0] ? mcand_q : 32'd0)};
    rem_shift = {rem_q[31:0], shreg_q[31]};
    rem_trial = {1'b0, rem_shift} - {2'b00, mcand_q};

    product   = neg_res_q ? (64'd0 - acc_q) : acc_q;
    quot_fix  = neg_res_q ? (32'd0 - shreg_q) : shreg_q;
    rem_fix   = neg_rem_q ? (32'd0 - rem_q[31:0]) : rem_q[31:0];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    mcand_d   = mcand_q;
    shreg_d   = shreg_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mthi) hi_d = wdata;
        if (mtlo) lo_d = wdata;
        if (start) begin
          state_d  = S_RUN;
          cnt_d    = '0;
          is_div_d = op[1];
          acc_d    = '0;
          rem_d    = '0;
          if (op[1]) begin
            // Zero divisor: feed the raw dividend with no sign flags, so the
            // restoring loop naturally yields quotient all-ones, remainder = rs.
            if (div_zero) begin
              mcand_d   = '0;
              shreg_d   = rs_value;
              neg_res_d = 1'b0;
              neg_rem_d = 1'b0;
            end else begin
              mcand_d   = rt_mag;
              shreg_d   = rs_mag;
              neg_res_d = rs_neg ^ rt_neg;
              neg_rem_d = rs_neg;
            end
          end else begin
            mcand_d   = rs_mag;
            shreg_d   = rt_mag;
            neg_res_d = rs_neg ^ rt_neg;
            neg_rem_d = 1'b0;
          end
        end
      end

      S_RUN: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIX;
        if (is_div_q) begin
          if (!rem_trial[33]) begin
            rem_d   = rem_trial[32:0];
            shreg_d = {shreg_q[30:0], 1'b1};
          end else begin
            rem_d   = rem_shift;
            shreg_d = {shreg_q[30:0], 1'b0};
          end
        end else begin
          acc_d   = {mul_sum, acc_q[31:1]};
          shreg_d = {1'b0, shreg_q[31:1]};
        end
      end

      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end else begin
          hi_d = product[63:32];
          lo_d = product[31:0];
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      mcand_q   <= '0;
      shreg_q   <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else if (clk_enable) begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      mcand_q   <= mcand_d;
      shreg_q   <= shreg_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed and randomized checks of mips_muldiv_unit against an arithmetic
// reference model of MULT/MULTU/DIV/DIVU and MTHI/MTLO.
module tb_mips_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        clk_enable;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_value;
  logic [31:0] rt_value;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int total;
  int bad;

  mips_muldiv_unit dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .start      (start),
    .op         (op),
    .rs_value   (rs_value),
    .rt_value   (rt_value),
    .mthi       (mthi),
    .mtlo       (mtlo),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: {hi, lo} straight from integer arithmetic.
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: begin
        q = sa * sb;
        return q;
      end
      2'b01: begin
        u = {32'd0, a} * {32'd0, b};
        return u;
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (o == 2'b10) begin
          q = sa / sb;
          r = sa % sb;
          return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Launch one operation and follow it to completion. Optional disturbances:
  // a clk_enable stall, a start/MTHI/MTLO injection while busy, and holding
  // clk_enable low while done is high.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int exp_lat, input int stall_at, input int stall_len,
                        input int inj_at, input bit hold_done);
    logic [63:0] exp_r;
    int cyc;
    int busy_n;
    exp_r = ref_result(o, a, b);
    @(negedge clk);
    start = 1'b1; op = o; rs_value = a; rt_value = b;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    cyc = 0;
    busy_n = busy ? 1 : 0;
    while (done !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_n++;
      if (cyc == stall_at) clk_enable = 1'b0;
      if (cyc == stall_at + stall_len) clk_enable = 1'b1;
      if (cyc == inj_at) begin
        start = 1'b1; mthi = 1'b1; mtlo = 1'b1; wdata = 32'hDEAD_BEEF;
        op = 2'b01; rs_value = $urandom; rt_value = $urandom;
      end
      if (cyc == inj_at + 1) begin
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      end
    end
    clk_enable = 1'b1;
    check("latency", cyc, exp_lat);
    check("busy_cycles", busy_n, exp_lat);
    check("busy_at_done", {31'd0, busy}, 32'd0);
    check("hi", hi, exp_r[63:32]);
    check("lo", lo, exp_r[31:0]);
    if (hold_done) begin
      clk_enable = 1'b0;
      repeat (2) @(negedge clk);
      check("done_held", {31'd0, done}, 32'd1);
      check("lo_held", lo, exp_r[31:0]);
      clk_enable = 1'b1;
    end
    @(negedge clk);
    check("done_pulse_end", {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic [31:0] specials [8];
    logic [31:0] a, b;
    logic [1:0]  o;
    int done_seen;

    total = 0;
    bad = 0;
    specials = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000,
                 32'h7FFF_FFFF, 32'h2, 32'hFFFF_FFFE, 32'h0001_0000};
    reset = 1'b1; clk_enable = 1'b1; start = 1'b0; op = 2'b00;
    rs_value = '0; rt_value = '0; mthi = 1'b0; mtlo = 1'b0; wdata = '0;

    repeat (3) @(negedge clk);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b0;

    // MTHI alone, then both MTHI and MTLO together
    @(negedge clk);
    mthi = 1'b1; wdata = 32'hAAAA_0000;
    @(negedge clk);
    mthi = 1'b0;
    check("mthi_hi", hi, 32'hAAAA_0000);
    check("mthi_lo_untouched", lo, 32'd0);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h1234_5678;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    check("mthilo_hi", hi, 32'h1234_5678);
    check("mthilo_lo", lo, 32'h1234_5678);

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, -10, 0, -10, 1'b1);
    run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 33, -10, 0, -10, 1'b0);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 33, -10, 0, -10, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 33, -10, 0, -10, 1'b0);
    run_op(2'b11, 32'd100, 32'd7, 33, -10, 0, -10, 1'b0);
    run_op(2'b11, 32'h1234_5678, 32'd0, 33, -10, 0, -10, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 33, -10, 0, -10, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd0, 33, -10, 0, -10, 1'b0);
    // start/MTHI/MTLO while busy must not disturb the in-flight DIV
    run_op(2'b10, 32'hFFFF_FC18, 32'd13, 33, -10, 0, 12, 1'b0);
    // five stalled edges mid-RUN
    run_op(2'b01, 32'd3, 32'd5, 38, 10, 5, -10, 1'b0);

    // reset in the middle of an operation
    @(negedge clk);
    start = 1'b1; op = 2'b01; rs_value = 32'd3; rt_value = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("midrst_no_done", done_seen, 0);
    check("midrst_busy_after", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 7)] : 32'($urandom);
      b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 7)] : 32'($urandom);
      if ($urandom_range(0, 7) == 0) b = $urandom_range(1, 20);
      run_op(o, a, b, 33, -10, 0, -10, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
